cnn_res_writer: RTL and testbench
=================================

# cnn_res_writer

- Parametrised result write-back engine for the CNN accelerator; next generation of the per-filter result buffering.
- Accepts up to `CH` parallel result words per cycle from the conv/pool datapath and queues each in a `DEPTH`-entry channel FIFO.
- Drains the FIFOs to memory over the shared lacc data-request port.
- Each channel has its own runtime-configured base address and address stride; drain order is selectable between strict channel sequence and round-robin.

## Interface
Parameters:
- `CH` (8): number of result channels (filters); ≥2.
- `DEPTH` (4): entries per channel FIFO; power of two, ≥2.
- `DW` (32): result word width.
- `AW` (32): address width.
- `SW` (16): stride width; the stride is zero-extended to `AW`.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` input, 1: clock.
- `rst` input, 1: asynchronous, active-low reset.
- `flush` input, 1: synchronous clear of FIFOs and arbitration state.
- `cfg_valid` input, 1: load the channel address configuration.
- `cfg_ch` input, clog2(CH): channel selected by `cfg_valid`.
- `cfg_base` input, AW: new base address for `cfg_ch`.
- `cfg_stride` input, SW: address increment per write for `cfg_ch`.
- `cfg_mode` input, 1: drain order; 0 = round-robin, 1 = strict sequence. Sampled on `start`.
- `start` input, 1: begin a layer; resets the order pointer and latches `cfg_mode`.
- `in_valid` input, CH: per-channel result valid.
- `in_data` input, CH*DW: result words; channel i occupies bits `[i*DW +: DW]`.
- `in_ready` output, 1: global accept; low when any FIFO is full.
- `mem_valid` output, 1: write request.
- `mem_ready` input, 1: memory port accepts the request.
- `mem_addr` output, AW: write address.
- `mem_wdata` output, DW: write data.
- `mem_ch` output, clog2(CH): channel being written.
- `empty` output, 1: all FIFOs empty and no request pending.
- `full` output, CH: per-channel FIFO full.

## Operation
- **Push.** In each cycle with `in_ready`, every channel i with `in_valid[i]` pushes `in_data` slice i.
  - `in_ready` = ~|full. A full FIFO blocks all channels, so results stay in lockstep.
  - A push is refused when a FIFO is full even if that FIFO pops in the same cycle.
- **Address registers.** Each channel has one address register.
  - `cfg_valid` loads `cfg_base`.
  - Each write handshake on that channel adds the zero-extended stride, modulo 2^AW.
  - If `cfg_valid` and a handshake target the same channel in the same cycle, the cfg load wins.
- **Arbitration state machine, IDLE / REQ.**
  - IDLE: select a grant from the non-empty FIFOs and go to REQ.
    - Strict mode (1): the grant is only the channel at `ptr`. If that channel is empty, stay in IDLE; do not skip it.
    - Round-robin mode (0): the grant is the lowest-indexed non-empty channel ≥ `ptr`, wrapping around.
  - REQ: `mem_valid`=1.
    - `mem_ch`, `mem_addr` and `mem_wdata` (the FIFO head) are held stable until `mem_ready`.
    - On handshake: pop that FIFO, advance the channel address, set `ptr` = grant+1 mod CH, return to IDLE.
- **`ptr` reset.** `start` clears `ptr` to 0. If `start` occurs while in REQ, the pending request completes first, and `ptr` is cleared after it.
- **`flush`.** Empties all FIFOs, returns to IDLE, clears `ptr`, deasserts `mem_valid` next cycle. Address registers are kept.
- **Asynchronous reset.** All state cleared immediately, including address registers and mode (mode resets to round-robin).

## Timing
- Reset values:
  - `in_ready`=1, `empty`=1, `full`=0, `mem_valid`=0.
  - `mem_addr`, `mem_wdata` and `mem_ch` are 0.
- Latency from push to request:
  - A word pushed at edge t into an empty engine gives `mem_valid`=1 after edge t+1.
  - The arbitration cycle is registered.
- Throughput: one write per 2 cycles (IDLE→REQ→IDLE). Back-to-back handshakes are not required.
- FIFO pointers use head/tail plus a wrap bit.
  - full = pointers equal and wrap bits differ.
  - empty = pointers equal and wrap bits equal.
  - A FIFO that is full at DEPTH entries is popped by a handshake one edge before `in_ready` rises.
- `empty` is high only when every FIFO is empty and the state is IDLE.

## Structure
- Package `cnn_res_pkg`:
  - drain-mode constants `RES_RR` and `RES_SEQ`;
  - state encoding `RES_IDLE` and `RES_REQ`;
  - `RES_SIZE_WORD` = 2'b10, for the lacc size field at the top level.
- Sub-module `cnn_res_fifo`: single-channel FIFO of width `DW` and depth `DEPTH`. Ports: push, pop, data, full, empty.
  - Instantiate it `CH` times in a generate loop.
  - Arbitration and address logic stay in `cnn_res_writer`.

## Test plan
- Reset, then a single push: `cfg` ch0 base 0x1000, stride 4; push ch0 0xA5 → `mem_valid` 2 cycles later, addr 0x1000, data 0xA5, `mem_ch`=0; the next ch0 write goes to 0x1004.
- Strict mode with CH=4: push ch1 and ch2 only → no request until ch0 and then ch3 are pushed; after those pushes, writes are issued in channel order 0,1,2,3.
- Round-robin mode: ch3 and ch1 non-empty, `ptr`=2 → ch3 granted first, then ch1; `ptr`=2 after the ch1 handshake.
- Backpressure: hold `mem_ready`=0 for 5 cycles → `mem_addr`, `mem_wdata` and `mem_ch` are unchanged, and DEPTH pushes to one channel drive `in_ready` low; the first handshake re-enables `in_ready` on the next cycle.
- Collision and wrap: `cfg_valid` on ch2 in the same cycle as a ch2 handshake → the address equals the new `cfg_base`; base 0xFFFF_FFFC with stride 8 wraps to 0x4.
- Flush, then asynchronous reset: `flush` with 3 FIFOs non-empty → `empty`=1 next cycle and address registers unchanged; a `rst` pulse mid-REQ → `mem_valid`=0 immediately and addresses read 0.

Source files
------------

// File: rtl/cnn_res_pkg.sv
// Shared constants for the CNN result write-back engine: drain modes, arbiter
// state encoding and the lacc transfer size used for every result word.
package cnn_res_pkg;

  localparam logic RES_RR  = 1'b0;
  localparam logic RES_SEQ = 1'b1;

  localparam logic [1:0] RES_SIZE_WORD = 2'b10;

  typedef enum logic {
    RES_IDLE = 1'b0,
    RES_REQ  = 1'b1
  } res_state_e;

endpackage

// File: rtl/cnn_res_writer_if.sv
// Result input bus plus the lacc data-request write port of the result writer.
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds valid and payload stable until then.
interface cnn_res_writer_if #(
    parameter int CH = 8,
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [CH-1:0]         in_valid;
    logic [CH*DW-1:0]      in_data;
    logic                  in_ready;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [$clog2(CH)-1:0] mem_ch;
    logic [1:0]            mem_size;

    modport master (
        output in_valid, in_data, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_ch, mem_size
    );

    modport slave (
        input  in_valid, in_data, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_ch, mem_size
    );
endinterface

// File: rtl/cnn_res_fifo.sv
// Single-channel result FIFO; head/tail pointers carry an extra wrap bit so that
// full and empty are told apart without an occupancy counter.
module cnn_res_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   wr_q;
    logic [PW:0]   rd_q;
    logic [DW-1:0] mem [DEPTH];

    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign empty = (wr_q == rd_q);
    assign rdata = mem[rd_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) wr_q <= wr_q + 1'b1;
            if (pop && !empty) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: the head is only observed while a request is open.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) mem[wr_q[PW-1:0]] <= wdata;
    end
endmodule

// File: rtl/cnn_res_writer.sv
// Result write-back engine: per-channel FIFOs drained one word at a time to the
// lacc write port, each channel with its own base address and stride.
module cnn_res_writer
    import cnn_res_pkg::*;
#(
    parameter int CH    = 8,
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int SW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cfg_valid,
    input  logic [$clog2(CH)-1:0] cfg_ch,
    input  logic [AW-1:0]         cfg_base,
    input  logic [SW-1:0]         cfg_stride,
    input  logic                  cfg_mode,
    input  logic                  start,
    cnn_res_writer_if.slave       bus,
    output logic                  empty,
    output logic [CH-1:0]         full,
    output res_state_e            dbg_state
);
    localparam int CW = $clog2(CH);

    res_state_e    state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] grant_q, grant_d;
    logic          mode_q;
    logic          start_pend_q, start_pend_d;
    logic          hs;
    logic          found;
    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    logic [CH-1:0] fifo_empty;
    logic [CH-1:0] push;
    logic [CH-1:0] pop;
    logic [DW-1:0] head   [CH];
    logic [AW-1:0] addr_q [CH];
    logic [SW-1:0] stride_q [CH];

    assign bus.in_ready = ~|full;
    assign hs           = (state_q == RES_REQ) && bus.mem_ready;

    for (genvar i = 0; i < CH; i++) begin : g_fifo
        assign push[i] = bus.in_ready && bus.in_valid[i] && !flush;
        assign pop[i]  = hs && (grant_q == CW'(i));

        cnn_res_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clear (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (bus.in_data[i*DW +: DW]),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (fifo_empty[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RES_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            mode_q       <= RES_RR;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            start_pend_q <= start_pend_d;
            if (start) mode_q <= cfg_mode;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        start_pend_d = start_pend_q;
        found        = 1'b0;
        sum          = '0;
        idx          = '0;
        case (state_q)
            RES_IDLE: begin
                if (start) begin
                    ptr_d = '0;
                end else if (mode_q == RES_SEQ) begin
                    // Strict order never skips an empty channel; it waits for it.
                    if (!fifo_empty[ptr_q]) begin
                        grant_d = ptr_q;
                        state_d = RES_REQ;
                    end
                end else begin
                    for (int k = 0; k < CH; k++) begin
                        sum = {1'b0, ptr_q} + (CW+1)'(k);
                        if (sum >= (CW+1)'(CH)) sum = sum - (CW+1)'(CH);
                        idx = sum[CW-1:0];
                        if (!found && !fifo_empty[idx]) begin
                            found   = 1'b1;
                            grant_d = idx;
                            state_d = RES_REQ;
                        end
                    end
                end
            end
            RES_REQ: begin
                // A start seen mid-request is remembered and applied after the write.
                if (start) start_pend_d = 1'b1;
                if (hs) begin
                    state_d      = RES_IDLE;
                    start_pend_d = 1'b0;
                    if (start || start_pend_q) ptr_d = '0;
                    else if (grant_q == CW'(CH-1)) ptr_d = '0;
                    else ptr_d = grant_q + 1'b1;
                end
            end
            default: state_d = RES_IDLE;
        endcase
        if (flush) begin
            state_d      = RES_IDLE;
            ptr_d        = '0;
            start_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                addr_q[i]   <= '0;
                stride_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cfg_valid && (cfg_ch == CW'(i))) begin
                    addr_q[i]   <= cfg_base;
                    stride_q[i] <= cfg_stride;
                end else if (pop[i]) begin
                    addr_q[i] <= addr_q[i] + {{(AW-SW){1'b0}}, stride_q[i]};
                end
            end
        end
    end

    assign bus.mem_valid = (state_q == RES_REQ);
    assign bus.mem_ch    = bus.mem_valid ? grant_q : '0;
    assign bus.mem_addr  = bus.mem_valid ? addr_q[grant_q] : '0;
    assign bus.mem_wdata = bus.mem_valid ? head[grant_q] : '0;
    assign bus.mem_size  = RES_SIZE_WORD;
    assign empty         = (&fifo_empty) && (state_q == RES_IDLE);
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_cnn_res_writer.sv
// Bench for cnn_res_writer with CH=4: scoreboarded write stream plus per-scenario
// inline checks of latency, ordering, backpressure, collisions, flush and reset.
module tb_cnn_res_writer;
  import cnn_res_pkg::*;

  localparam int CH = 4;
  localparam int DEPTH = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 16;
  localparam int CW = 2;
  localparam int W = CW + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic cfg_valid = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [SW-1:0] cfg_stride = '0;
  logic cfg_mode = 1'b0;
  logic start = 1'b0;
  logic empty;
  logic [CH-1:0] full;
  res_state_e dbg_state;

  cnn_res_writer_if #(.CH(CH), .DW(DW), .AW(AW)) bus ();

  cnn_res_writer #(.CH(CH), .DEPTH(DEPTH), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_mode(cfg_mode), .start(start),
    .bus(bus), .empty(empty), .full(full), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [AW-1:0] m_addr[CH];
  logic [SW-1:0] m_stride[CH];

  // scoreboard: every accepted write is popped against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (rst && bus.mem_valid && bus.mem_ready) begin
      got = {bus.mem_ch, bus.mem_addr, bus.mem_wdata};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_write: got ch/addr/data %h, required none (queue empty)", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          tests_failed++;
          $display("FAIL sb_write: got ch/addr/data %h, required %h", got, want);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input int ch, input logic [DW-1:0] d);
    exp_q.push_back({CW'(ch), m_addr[ch], d});
    m_addr[ch] = m_addr[ch] + {16'b0, m_stride[ch]};
  endtask

  task automatic do_cfg(input int ch, input logic [AW-1:0] base, input logic [SW-1:0] stride);
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_base = base; cfg_stride = stride;
    step();
    cfg_valid = 1'b0;
    m_addr[ch] = base;
    m_stride[ch] = stride;
  endtask

  task automatic do_start(input logic mode);
    start = 1'b1; cfg_mode = mode;
    step();
    start = 1'b0;
  endtask

  task automatic push_one(input int ch, input logic [DW-1:0] d);
    bus.in_valid = '0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*DW +: DW] = d;
    step();
    bus.in_valid = '0;
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (empty && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    tests_run++;
    if ({bus.in_ready, empty, full, bus.mem_valid} !== {1'b1, 1'b1, 4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_flags: in_ready/empty/full/mem_valid %b, required 1_1_0000_0",
               {bus.in_ready, empty, full, bus.mem_valid});
    end
    tests_run++;
    if ({bus.mem_ch, bus.mem_addr, bus.mem_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: ch/addr/data %h, required 0",
               {bus.mem_ch, bus.mem_addr, bus.mem_wdata});
    end
    tests_run++;
    if (dbg_state !== RES_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: %0d, required %0d", dbg_state, RES_IDLE);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    do_cfg(0, 32'h1000, 16'd4);
    do_start(RES_RR);
    expect_write(0, 32'hA5);
    push_one(0, 32'hA5);
    tests_run++;
    if (bus.mem_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency1: mem_valid %b, required 0", bus.mem_valid);
    end
    step();
    tests_run++;
    if ({bus.mem_valid, bus.mem_ch, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'd0, 32'h1000, 32'hA5}) begin
      tests_failed++;
      $display("FAIL single_req: valid/ch/addr/data %h, required 1_0_1000_a5",
               {bus.mem_valid, bus.mem_ch, bus.mem_addr, bus.mem_wdata});
    end
    expect_write(0, 32'h5A);
    push_one(0, 32'h5A);
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_drain: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_strict();
    bit ok;
    bit seen;
    for (int i = 0; i < CH; i++) do_cfg(i, 32'h2000 + 32'h100 * i, 16'd4);
    do_start(RES_SEQ);
    bus.in_valid = 4'b0110;
    bus.in_data[1*DW +: DW] = 32'h51;
    bus.in_data[2*DW +: DW] = 32'h52;
    step();
    bus.in_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_valid) seen = 1'b1;
      step();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL strict_stall: request seen %b, required 0", seen);
    end
    expect_write(0, 32'h50);
    expect_write(1, 32'h51);
    expect_write(2, 32'h52);
    expect_write(3, 32'h53);
    push_one(0, 32'h50);
    push_one(3, 32'h53);
    wait_drained(60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL strict_order: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_rr();
    bit ok;
    do_start(RES_RR);
    expect_write(1, 32'h61);
    push_one(1, 32'h61);
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_setup: pending %0d, required 0", exp_q.size());
    end
    expect_write(3, 32'h73);
    expect_write(1, 32'h71);
    bus.in_valid = 4'b1010;
    bus.in_data[1*DW +: DW] = 32'h71;
    bus.in_data[3*DW +: DW] = 32'h73;
    step();
    bus.in_valid = '0;
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_wrap: pending %0d, required 0", exp_q.size());
    end
    expect_write(2, 32'h82);
    expect_write(0, 32'h80);
    expect_write(1, 32'h81);
    bus.in_valid = 4'b0111;
    bus.in_data[0*DW +: DW] = 32'h80;
    bus.in_data[1*DW +: DW] = 32'h81;
    bus.in_data[2*DW +: DW] = 32'h82;
    step();
    bus.in_valid = '0;
    wait_drained(60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_ptr_after: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit moved;
    do_cfg(2, 32'h3000, 16'h10);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_write(2, 32'hB000 + i);
      push_one(2, 32'hB000 + i);
    end
    tests_run++;
    if ({full, bus.in_ready} !== {4'b0100, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_full: full/in_ready %b, required 0100_0", {full, bus.in_ready});
    end
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({bus.mem_valid, bus.mem_ch, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'd2, 32'h3000, 32'hB000})
        moved = 1'b1;
      step();
    end
    tests_run++;
    if (moved !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold: ch/addr/data %h changed, required 2_3000_b000",
               {bus.mem_ch, bus.mem_addr, bus.mem_wdata});
    end
    // push attempted while full in the same cycle as the pop must be refused
    bus.mem_ready = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_data[2*DW +: DW] = 32'hDEAD_BEEF;
    step();
    bus.in_valid = '0;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_in_ready: in_ready %b, required 1", bus.in_ready);
    end
    wait_drained(60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bp_drain: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_collision();
    bit ok;
    do_cfg(2, 32'h4000, 16'd4);
    bus.mem_ready = 1'b0;
    exp_q.push_back({2'd2, 32'h4000, 32'hC1});
    exp_q.push_back({2'd2, 32'h5000, 32'hC2});
    m_addr[2] = 32'h5004;
    push_one(2, 32'hC1);
    push_one(2, 32'hC2);
    tests_run++;
    if (bus.mem_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL col_req: mem_valid %b, required 1", bus.mem_valid);
    end
    bus.mem_ready = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_base = 32'h5000; cfg_stride = 16'd4;
    step();
    cfg_valid = 1'b0;
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL col_cfg_wins: pending %0d, required 0", exp_q.size());
    end
    do_cfg(1, 32'hFFFF_FFFC, 16'd8);
    expect_write(1, 32'hE1);
    expect_write(1, 32'hE2);
    push_one(1, 32'hE1);
    push_one(1, 32'hE2);
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL addr_wrap: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    bit ok;
    bus.mem_ready = 1'b0;
    bus.in_valid = 4'b0111;
    bus.in_data = {32'h0, 32'hF2, 32'hF1, 32'hF0};
    step();
    bus.in_valid = '0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if ({empty, bus.mem_valid, full} !== {1'b1, 1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL flush_empty: empty/mem_valid/full %b, required 1_0_0000",
               {empty, bus.mem_valid, full});
    end
    bus.mem_ready = 1'b1;
    expect_write(0, 32'hF9);
    push_one(0, 32'hF9);
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL flush_addr_kept: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.mem_ready = 1'b0;
    push_one(3, 32'h77);
    step();
    tests_run++;
    if (bus.mem_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ar_req: mem_valid %b, required 1", bus.mem_valid);
    end
    #3 rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_valid, bus.mem_addr, empty} !== {1'b0, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ar_immediate: valid/addr/empty %h, required 0_0_1",
               {bus.mem_valid, bus.mem_addr, empty});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < CH; i++) begin
      m_addr[i] = '0;
      m_stride[i] = '0;
    end
    bus.mem_ready = 1'b1;
    expect_write(1, 32'h88);
    expect_write(1, 32'h99);
    push_one(1, 32'h88);
    push_one(1, 32'h99);
    wait_drained(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL ar_addr_zero: pending %0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      m_addr[i] = '0;
      m_stride[i] = '0;
    end
    test_reset();
    test_single();
    test_strict();
    test_rr();
    test_backpressure();
    test_collision();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
